mips_bus_arbiter: RTL and testbench
===================================

Name: mips_bus_arbiter

Overview:
- Two-master to one-slave arbiter for the CPU's Avalon memory-mapped bus.
- Master 0 is the instruction-fetch port; master 1 is the load/store data port.
- Grants the single external Avalon bus to one master per transaction and holds the grant until the slave drops waitrequest.
- Provides a stall watchdog that flags a hung slave.

Parameters:
- TIMEOUT, 1023: waitrequest-stall cycles before bus_error asserts; 0 disables the watchdog.
- TO_W, 10: width of the stall counter; must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m0_address  in  32  instruction-fetch address
- m0_read  in  1  instruction-fetch read request
- m0_waitrequest  out  1  stall to master 0
- m0_readdata  out  32  read data to master 0
- m1_address  in  32  data-port address
- m1_read  in  1  data-port read request
- m1_write  in  1  data-port write request
- m1_writedata  in  32  data-port write data
- m1_byteenable  in  4  data-port byte enables
- m1_waitrequest  out  1  stall to master 1
- m1_readdata  out  32  read data to master 1
- address  out  32  bus address
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- writedata  out  32  bus write data
- byteenable  out  4  bus byte enables
- waitrequest  in  1  slave stall
- readdata  in  32  slave read data
- grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1)
- bus_error  out  1  sticky watchdog flag

Behaviour:
- States: IDLE, OWN0, OWN1. The state register is the only source of grant.
- Reset (reset low, asynchronous):
  - state = IDLE, grant = 0, bus_error = 0, stall counter = 0, round-robin pointer = 0.
  - read, write = 0; address, writedata = 0; byteenable = 0.
  - m0_waitrequest = m1_waitrequest = 1.
- A request is m0_read for master 0, and (m1_read | m1_write) for master 1.
- IDLE:
  - All bus strobes are 0; both masters see waitrequest = 1.
  - Next state = OWN1 if only m1 requests, OWN0 if only m0 requests.
  - If both request, the winner is chosen by the priority rule.
  - No requests: stay in IDLE.
  - Arbitration latency is one cycle: the request is seen in IDLE and the bus is driven in the following cycle.
- OWNx:
  - Bus outputs are combinationally muxed from master x.
  - For master 0: write = 0, writedata = 0, byteenable = 4'b1111.
  - mx_waitrequest = waitrequest; the other master's waitrequest is forced to 1.
  - readdata is broadcast to both m*_readdata; it is valid only for the owner in the cycle waitrequest is low.
- Completion: in OWNx with waitrequest = 0, the transfer completes that cycle.
  - Next state is chosen by the IDLE rules using the current-cycle requests, excluding the master that just completed (it must re-present).
  - This gives back-to-back handover with no idle cycle.
- Abort: if the owner drops its request while waitrequest = 1, return to IDLE next cycle. The bus strobe is 0 in that same cycle because it is combinational from the master.
- Priority (no macro): fixed, m1 > m0. Data accesses must not starve behind fetch.
- Watchdog (TIMEOUT ≠ 0):
  - The counter increments each cycle in OWNx with waitrequest = 1 and clears on completion, abort, or IDLE.
  - When the counter reaches TIMEOUT, bus_error sets and is sticky until reset.
  - The transfer is not killed.
  - The counter saturates and does not wrap.
- Simultaneous completion and new requests: completion has precedence; the grant changes on the next edge only.
- Requests arriving during OWNx are held off by waitrequest = 1; requests are not queued.

Optional Feature:
- Macro: MIPS_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit pointer selects the winner on simultaneous requests.
  - The pointer points to the master that did not win last; it is updated on every completion and reset to 0, favouring m0 first.
- Undefined: fixed m1 > m0 priority; no pointer register.

Decomposition:
- Shared package mips_bus_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, OWN0, OWN1}
  - localparams GRANT_M0 = 2'b01 and GRANT_M1 = 2'b10
  - localparam BE_WORD = 4'b1111
- One sub-module is natural: mips_bus_watchdog (stall counter plus sticky error), parameterised by TIMEOUT and TO_W.

Test Plan:
- Fetch only: m0_read = 1, m0_address = 0xBFC00000, slave waitrequest = 1 for 2 cycles, readdata = 0x24020005.
  - Expect grant = 01 one cycle later.
  - Expect m0_readdata = 0x24020005 with m0_waitrequest = 0 on the 3rd owned cycle.
  - m1_waitrequest stays 1 throughout.
- Collision: m0_read and m1_write (address 0x1000, writedata 0xDEADBEEF, byteenable 0011) asserted together.
  - Without macro: the bus shows the m1 write first, then the m0 read follows back-to-back with no IDLE cycle.
  - With macro from reset: m0 goes first.
- Round-robin fairness with macro: both masters hold requests for 6 transfers, waitrequest = 0.
  - Expect grant to alternate 01, 10, 01, 10, 01, 10.
- Watchdog: TIMEOUT = 4, m1_read held, waitrequest stuck at 1.
  - Expect bus_error = 1 after 4 stalled cycles.
  - bus_error stays 1 after waitrequest falls, until reset.
- Abort and reset mid-operation:
  - Owner drops m1_read while stalled: expect state IDLE next cycle and read = 0.
  - Pulse reset low mid-transfer asynchronously: expect grant = 0, read = write = 0 and both waitrequests = 1 before the next clock edge.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the two-master Avalon bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    localparam logic [1:0] GRANT_M0 = 2'b01;
    localparam logic [1:0] GRANT_M1 = 2'b10;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    // win1 breaks a tie in favour of master 1 when set
    function automatic arb_state_t arb_pick(input logic r0, input logic r1, input logic win1);
        if (r1 && (!r0 || win1)) begin
            return OWN1;
        end else if (r0) begin
            return OWN0;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// Stall watchdog: saturating count of stalled owned cycles plus a sticky error flag.
// TIMEOUT = 0 disables the flag entirely.
module mips_bus_watchdog #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TO_W    = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_i,
    output logic error_o
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if (TIMEOUT != 0) begin
            if (stall_i) begin
                cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + TO_W'(1);
            end
            if (cnt_d == LIMIT && stall_i) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign error_o = err_q;

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master (fetch, load/store) to one-slave Avalon arbiter with stall watchdog.
// Define MIPS_ARB_ROUND_ROBIN_EN for round-robin tie-breaking instead of fixed m1 > m0.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TO_W    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [1:0]  grant,
    output logic        bus_error
);

    arb_state_t state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       req0, req1, win1, stall;

    assign req0 = m0_read;
    assign req1 = m1_read | m1_write;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    // Points at the master that did not win the last completed transfer
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q != IDLE && !waitrequest) begin
            ptr_d = (state_q == OWN0);
        end
    end

    assign win1 = ptr_q;
`else
    assign win1 = 1'b1;
`endif

    // A completing owner is excluded so it must re-present its request
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = arb_pick(req0, req1, win1);
            OWN0: begin
                if (!waitrequest) begin
                    state_d = arb_pick(1'b0, req1, win1);
                end else if (!req0) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (!waitrequest) begin
                    state_d = arb_pick(req0, 1'b0, win1);
                end else if (!req1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = 2'b00;
        if (state_d == OWN0) begin
            grant_d = GRANT_M0;
        end else if (state_d == OWN1) begin
            grant_d = GRANT_M1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Bus side is a straight mux from the owner; strobes follow the master combinationally
    always_comb begin
        address        = '0;
        read           = 1'b0;
        write          = 1'b0;
        writedata      = '0;
        byteenable     = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state_q)
            OWN0: begin
                address        = m0_address;
                read           = m0_read;
                byteenable     = BE_WORD;
                m0_waitrequest = waitrequest;
            end
            OWN1: begin
                address        = m1_address;
                read           = m1_read;
                write          = m1_write;
                writedata      = m1_writedata;
                byteenable     = m1_byteenable;
                m1_waitrequest = waitrequest;
            end
            default: ;
        endcase
    end

    assign m0_readdata = readdata;
    assign m1_readdata = readdata;
    assign grant       = grant_q;

    assign stall = waitrequest && ((state_q == OWN0 && req0) || (state_q == OWN1 && req1));

    mips_bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .stall_i (stall),
        .error_o (bus_error)
    );

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter (watchdog TIMEOUT = 4).
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address, m1_writedata, readdata;
    logic        m0_read, m1_read, m1_write, waitrequest;
    logic [3:0]  m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, address, writedata;
    logic        read, write, bus_error;
    logic [3:0]  byteenable;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(
        .TIMEOUT (4),
        .TO_W    (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_byteenable  (m1_byteenable),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .address        (address),
        .read           (read),
        .write          (write),
        .writedata      (writedata),
        .byteenable     (byteenable),
        .waitrequest    (waitrequest),
        .readdata       (readdata),
        .grant          (grant),
        .bus_error      (bus_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    logic [1:0] exp_g;

    initial begin
        reset = 1'b0;
        m0_address = '0; m0_read = 0; m1_address = '0; m1_read = 0; m1_write = 0;
        m1_writedata = '0; m1_byteenable = '0; waitrequest = 1; readdata = '0;
        #2;
        chk("rst_grant", grant, 2'b00);
        chk("rst_read", read, 1'b0);
        chk("rst_write", write, 1'b0);
        chk("rst_addr", address, 32'h0);
        chk("rst_be", byteenable, 4'h0);
        chk("rst_m0wait", m0_waitrequest, 1'b1);
        chk("rst_m1wait", m1_waitrequest, 1'b1);
        chk("rst_err", bus_error, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        // Fetch only: two stalled cycles, data on the third owned cycle
        m0_read = 1; m0_address = 32'hBFC0_0000; readdata = 32'h2402_0005; waitrequest = 1;
        #1 chk("f_idle_grant", grant, 2'b00);
        chk("f_idle_read", read, 1'b0);
        tick();
        chk("f_grant", grant, 2'b01);
        chk("f_addr", address, 32'hBFC0_0000);
        chk("f_read", read, 1'b1);
        chk("f_be", byteenable, 4'hF);
        chk("f_m0wait1", m0_waitrequest, 1'b1);
        chk("f_m1wait1", m1_waitrequest, 1'b1);
        tick();
        chk("f_grant2", grant, 2'b01);
        tick();
        waitrequest = 0;
        #1 chk("f_m0wait3", m0_waitrequest, 1'b0);
        chk("f_rdata", m0_readdata, 32'h2402_0005);
        chk("f_m1wait3", m1_waitrequest, 1'b1);
        m0_read = 0;
        tick();
        chk("f_done_grant", grant, 2'b00);
        chk("f_err", bus_error, 1'b0);
        waitrequest = 1;
        do_reset();

        // Collision: write from m1 and fetch from m0 together, slave ready
        m0_read = 1; m0_address = 32'h0000_0100;
        m1_write = 1; m1_address = 32'h0000_1000; m1_writedata = 32'hDEAD_BEEF;
        m1_byteenable = 4'b0011; waitrequest = 0;
        tick();
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        chk("c_first_grant", grant, 2'b01);
        chk("c_first_addr", address, 32'h0000_0100);
        chk("c_first_read", read, 1'b1);
        chk("c_first_write", write, 1'b0);
        m0_read = 0;
        tick();
        chk("c_second_grant", grant, 2'b10);
        chk("c_second_write", write, 1'b1);
        chk("c_second_wdata", writedata, 32'hDEAD_BEEF);
        chk("c_second_be", byteenable, 4'b0011);
        m1_write = 0;
`else
        chk("c_first_grant", grant, 2'b10);
        chk("c_first_addr", address, 32'h0000_1000);
        chk("c_first_write", write, 1'b1);
        chk("c_first_read", read, 1'b0);
        chk("c_first_wdata", writedata, 32'hDEAD_BEEF);
        chk("c_first_be", byteenable, 4'b0011);
        m1_write = 0;
        tick();
        chk("c_second_grant", grant, 2'b01);
        chk("c_second_addr", address, 32'h0000_0100);
        chk("c_second_read", read, 1'b1);
        chk("c_second_write", write, 1'b0);
        chk("c_second_wdata", writedata, 32'h0);
        chk("c_second_be", byteenable, 4'hF);
        m0_read = 0;
`endif
        tick();
        chk("c_idle_grant", grant, 2'b00);
        do_reset();

        // Both masters hold requests for six zero-wait transfers
        m0_read = 1; m1_read = 1; m1_address = 32'h0000_2000; waitrequest = 0;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        exp_g = 2'b01;
`else
        exp_g = 2'b10;
`endif
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rr_grant%0d", i), grant, exp_g);
            exp_g = ~exp_g;
        end
        m0_read = 0; m1_read = 0;
        tick();
        chk("rr_idle", grant, 2'b00);
        do_reset();

        // Watchdog: m1 read stuck behind a hung slave
        m1_read = 1; waitrequest = 1;
        tick();
        chk("wd_grant", grant, 2'b10);
        tick(); tick(); tick();
        chk("wd_err3", bus_error, 1'b0);
        tick();
        chk("wd_err4", bus_error, 1'b1);
        chk("wd_grant_held", grant, 2'b10);
        tick(); tick(); tick(); tick(); tick();
        chk("wd_err_sat", bus_error, 1'b1);
        waitrequest = 0;
        #1 chk("wd_m1wait", m1_waitrequest, 1'b0);
        m1_read = 0;
        tick();
        chk("wd_done_grant", grant, 2'b00);
        chk("wd_sticky", bus_error, 1'b1);
        tick();
        chk("wd_sticky2", bus_error, 1'b1);
        do_reset();
        chk("wd_cleared", bus_error, 1'b0);

        // Abort: owner withdraws while stalled
        m1_read = 1; m1_address = 32'h0000_3000; waitrequest = 1;
        tick();
        chk("ab_grant", grant, 2'b10);
        chk("ab_read", read, 1'b1);
        m1_read = 0;
        #1 chk("ab_read_same", read, 1'b0);
        tick();
        chk("ab_idle", grant, 2'b00);
        chk("ab_read_next", read, 1'b0);
        chk("ab_m1wait", m1_waitrequest, 1'b1);

        // Asynchronous reset in the middle of a stalled fetch
        m0_read = 1; m0_address = 32'h0000_4000;
        tick();
        tick();
        chk("ar_grant_before", grant, 2'b01);
        chk("ar_read_before", read, 1'b1);
        #1 reset = 1'b0;
        #1 chk("ar_grant", grant, 2'b00);
        chk("ar_read", read, 1'b0);
        chk("ar_write", write, 1'b0);
        chk("ar_m0wait", m0_waitrequest, 1'b1);
        chk("ar_m1wait", m1_waitrequest, 1'b1);
        m0_read = 0;
        tick();
        reset = 1'b1;
        tick();
        chk("ar_after_grant", grant, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
